// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the memory arbiter state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        D_ACC,
        I_ACC
    } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Counts stalled RAM cycles of the current access and flags the cycle in which
// the access has to be abandoned.
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RST,
    input  logic active,
    input  logic ram_ready,
    output logic expire
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tcnt;

    // Held at zero while the arbiter is idle, so every access starts from a fresh count.
    always_ff @(posedge CLK) begin
        if (RST || !active) begin
            tcnt <= '0;
        end else if (!ram_ready) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign expire = active && !ram_ready && (tcnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data ports, with data
// priority, a fetch starvation guard and a watchdog on stuck RAM accesses.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  iREN,
    input  word_t iaddr,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t daddr,
    input  word_t dstore,
    output logic  iwait,
    output word_t iload,
    output logic  dwait,
    output word_t dload,
    output logic  ramREN,
    output logic  ramWEN,
    output word_t ramaddr,
    output word_t ramstore,
    input  word_t ramload,
    input  logic  ram_ready,
    output logic  err
);

    localparam int SW = $clog2(MAX_DSTREAK + 1);

    arb_state_t    state;
    logic [SW-1:0] dstreak;
    word_t         addr_q;
    word_t         store_q;
    logic          wr_q;
    logic          expire;
    logic          done;
    logic          d_req;
    logic          force_i;

    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .CLK      (CLK),
        .RST      (RST),
        .active   (state != IDLE),
        .ram_ready(ram_ready),
        .expire   (expire)
    );

    assign d_req   = dREN | dWEN;
    assign force_i = iREN && (dstreak == SW'(MAX_DSTREAK));
    // Reset suppresses completion so an abandoned access never emits a response pulse.
    assign done    = !RST && (ram_ready || expire);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            dstreak <= '0;
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && !force_i) begin
                        state   <= D_ACC;
                        addr_q  <= daddr;
                        store_q <= dstore;
                        wr_q    <= dWEN;
                        if (!iREN) begin
                            dstreak <= '0;
                        end else if (dstreak != SW'(MAX_DSTREAK)) begin
                            dstreak <= dstreak + 1'b1;
                        end
                    end else if (iREN) begin
                        state   <= I_ACC;
                        addr_q  <= iaddr;
                        wr_q    <= 1'b0;
                        dstreak <= '0;
                    end
                end
                D_ACC, I_ACC: begin
                    if (done) begin
                        state <= IDLE;
                    end
                    if (expire) begin
                        err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A timed-out access completes with zero data on the owning port.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            D_ACC: begin
                ramaddr  = addr_q;
                ramWEN   = wr_q;
                ramREN   = !wr_q;
                ramstore = store_q;
                if (done) begin
                    dwait = 1'b0;
                    if (ram_ready && !wr_q) begin
                        dload = ramload;
                    end
                end
            end
            I_ACC: begin
                ramREN  = 1'b1;
                ramaddr = addr_q;
                if (done) begin
                    iwait = 1'b0;
                    if (ram_ready) begin
                        iload = ramload;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter between the instruction-fetch port (imem) and the data port (dmem) of the pipelined datapath, in front of one shared RAM.
- Serialises requests, with data priority and a starvation guard for fetch.
- Drives the per-port wait signals that the datapath's ihit/dhit derive from.
- A watchdog aborts RAM accesses that never complete.

Parameters:
- MAX_DSTREAK, 4: consecutive data grants allowed while a fetch is pending before the fetch is forced.
- TIMEOUT, 64: ACCESS-state cycles allowed without ram_ready before an abort.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset. One clock; reset is synchronous and active-high.
- iREN  in  1  fetch read request; held until iwait is low.
- iaddr  in  32  fetch word address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins if asserted together with dREN.
- daddr  in  32  data address.
- dstore  in  32  write data.
- iwait  out  1  low for exactly the completion cycle of a fetch.
- iload  out  32  fetch data; valid when iwait is low.
- dwait  out  1  low for exactly the completion cycle of a data access.
- dload  out  32  read data; valid when dwait is low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ram_ready  in  1  RAM completes the current access this cycle.
- err  out  1  sticky timeout flag.

Behaviour:
- States: IDLE, D_ACC, I_ACC. State and counters are registered; wait, load and ram* outputs are combinational from state, latched request and ram_ready.
- Reset (sampled at a rising edge with RST=1):
  - state=IDLE, dstreak=0, tcnt=0, err=0, latched addr/store/write-flag=0.
  - Outputs in IDLE: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- IDLE arbitration, one cycle:
  - If (dREN|dWEN) and not (iREN and dstreak==MAX_DSTREAK): go to D_ACC. Latch daddr, dstore, write-flag=dWEN.
  - Else if iREN: go to I_ACC, latch iaddr.
  - Else stay in IDLE.
- dstreak:
  - +1 on a D grant while iREN=1, saturating at MAX_DSTREAK.
  - Cleared on any I grant.
  - Cleared on a D grant while iREN=0.
- D_ACC:
  - ramaddr = latched addr.
  - ramWEN = write-flag, ramREN = !write-flag, ramstore = latched store.
  - When ram_ready=1: dwait=0, dload=ramload (reads) or 0 (writes); next state IDLE.
- I_ACC: ramREN=1, ramaddr = latched addr. When ram_ready=1: iwait=0, iload=ramload; next state IDLE.
- Timing:
  - Minimum latency is 2 cycles from request to wait low (1 arbitration cycle + access with ram_ready in the same cycle).
  - Back-to-back accesses always pass through IDLE.
- Watchdog:
  - tcnt is cleared on entering an ACC state and increments each ACC cycle without ram_ready.
  - When tcnt==TIMEOUT-1 and ram_ready=0: the owning port's wait goes low, its load=32'h0, err<=1 (sticky until reset), next state IDLE.
- Requester dropping its request mid-access: the RAM access still completes; the response pulse is still issued and ignored.
- A request arriving during an ACC state waits; it is sampled in the next IDLE.
- iwait and dwait are never low in the same cycle.
- RST asserted mid-access: the access is abandoned, the state is IDLE in the following cycle, and no wait-low pulse is issued.

Decomposition:
- Add arb_state_t (IDLE, D_ACC, I_ACC) to cpu_types_pkg. word_t comes from that package.
- Optional sub-module arb_watchdog (tcnt counter + expire compare), instantiated once. Everything else is one module.

Test Plan:
- Idle fetch: iREN=1, iaddr=32'h40, ram_ready=1 on first I_ACC cycle, ramload=32'h2001_0005 -> ramREN=1 with ramaddr=32'h40 in cycle 2; iwait=0 and iload=32'h2001_0005 in cycle 2; iwait=1 in cycle 3.
- Simultaneous requests: iREN=1, dREN=1, daddr=32'h100, ram_ready always 1 -> D served first (dwait low in cycle 2), I served next (iwait low in cycle 4).
- Starvation: iREN held and dWEN held continuously, ram_ready=1 -> 4 data grants, then 1 fetch grant, then data again; dstreak returns to 0 after the fetch.
- Write: dWEN=1, dREN=1, daddr=32'h200, dstore=32'hDEAD_BEEF, ram_ready after 3 cycles -> ramWEN=1, ramREN=0, ramstore=32'hDEAD_BEEF for 4 D_ACC cycles; dwait low in the 4th; dload=0.
- Timeout: TIMEOUT=8, dREN=1, ram_ready=0 -> dwait low in the 8th D_ACC cycle with dload=0; err=1 from the next cycle and stays 1 through a following good fetch until RST.
- Reset mid-access: RST=1 during the 2nd I_ACC cycle -> no iwait pulse; next cycle ramREN=0, err=0, state IDLE; a new fetch completes normally.
